// File: rtl/seq_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : seq_dispenser
// Brief    : Double-buffered symbol dispenser for the restricted-move sequence
//            generator; pops one symbol per request, feeds back the last one.
// Revision : 1.0 - initial release
// ============================================================================
module seq_dispenser #(
    parameter int SYMW  = 2,
    parameter int NSYM  = 4,
    parameter int CHECK = 1,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SYMW*NSYM-1:0] seq_in,
    input  logic                 seq_valid,
    output logic                 seq_ready,
    input  logic                 pop,
    output logic [SYMW-1:0]      sym,
    output logic                 sym_valid,
    output logic [SYMW-1:0]      restrict_out,
    output logic                 perm_err,
    output logic                 pop_err,
    input  logic                 err_clr,
    output logic [CNTW-1:0]      seq_done_cnt
);

    localparam int SEQW = SYMW * NSYM;
    localparam int CW   = $clog2(NSYM + 1);
    localparam logic [CW-1:0] C_NSYM = CW'(NSYM);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [SEQW-1:0] r_cur;
    logic [CW-1:0]   r_cur_cnt;
    logic [SEQW-1:0] r_nxt;
    logic            r_nxt_full;
    logic [SYMW-1:0] r_restrict;
    logic            r_perm_err;
    logic            r_pop_err;
    logic [CNTW-1:0] r_done_cnt;

    logic w_accept;
    logic w_pop_ok;
    logic w_load_cur;
    logic w_dup;

    // Handshake and symbol outputs decode from registers only.
    assign sym          = r_cur[SYMW-1:0];
    assign sym_valid    = (r_cur_cnt != '0);
    assign seq_ready    = ~r_nxt_full;
    assign restrict_out = r_restrict;
    assign perm_err     = r_perm_err;
    assign pop_err      = r_pop_err;
    assign seq_done_cnt = r_done_cnt;

    assign w_accept   = seq_valid & seq_ready;
    assign w_pop_ok   = pop & sym_valid;
    assign w_load_cur = (r_cur_cnt == '0) | ((r_cur_cnt == C_ONE) & w_pop_ok);

    generate
        if (CHECK != 0) begin : g_check
            always_comb begin
                w_dup = 1'b0;
                for (int i = 0; i < NSYM; i++) begin
                    for (int j = i + 1; j < NSYM; j++) begin
                        if (seq_in[i*SYMW +: SYMW] == seq_in[j*SYMW +: SYMW]) begin
                            w_dup = 1'b1;
                        end
                    end
                end
            end
        end else begin : g_nocheck
            assign w_dup = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur      <= '0;
            r_cur_cnt  <= '0;
            r_nxt      <= '0;
            r_nxt_full <= 1'b0;
            r_restrict <= '0;
            r_perm_err <= 1'b0;
            r_pop_err  <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_load_cur) begin
                if (r_nxt_full) begin
                    r_cur     <= r_nxt;
                    r_cur_cnt <= C_NSYM;
                    if (w_accept) begin
                        r_nxt <= seq_in;
                    end else begin
                        r_nxt_full <= 1'b0;
                    end
                end else if (w_accept) begin
                    // Bypass: an empty dispenser loads straight from the input.
                    r_cur     <= seq_in;
                    r_cur_cnt <= C_NSYM;
                end else begin
                    r_cur_cnt <= '0;
                end
            end else begin
                if (w_pop_ok) begin
                    r_cur     <= r_cur >> SYMW;
                    r_cur_cnt <= r_cur_cnt - C_ONE;
                end
                if (w_accept) begin
                    r_nxt      <= seq_in;
                    r_nxt_full <= 1'b1;
                end
            end

            if (w_pop_ok) begin
                r_restrict <= r_cur[SYMW-1:0];
            end
            if (w_pop_ok && (r_cur_cnt == C_ONE)) begin
                r_done_cnt <= r_done_cnt + CNTW'(1);
            end

            // A new error event takes priority over a same-cycle clear.
            r_perm_err <= (r_perm_err & ~err_clr) | (w_accept & w_dup);
            r_pop_err  <= (r_pop_err & ~err_clr) | (pop & ~sym_valid);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_dispenser
// Brief    : Directed self-checking bench for seq_dispenser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_dispenser;

    logic        clk;
    logic        rst;
    logic [7:0]  seq_in;
    logic        seq_valid;
    logic        seq_ready;
    logic        pop;
    logic [1:0]  sym;
    logic        sym_valid;
    logic [1:0]  restrict_out;
    logic        perm_err;
    logic        pop_err;
    logic        err_clr;
    logic [15:0] seq_done_cnt;

    int total = 0;
    int bad   = 0;

    seq_dispenser #(
        .SYMW  (2),
        .NSYM  (4),
        .CHECK (1),
        .CNTW  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seq_in       (seq_in),
        .seq_valid    (seq_valid),
        .seq_ready    (seq_ready),
        .pop          (pop),
        .sym          (sym),
        .sym_valid    (sym_valid),
        .restrict_out (restrict_out),
        .perm_err     (perm_err),
        .pop_err      (pop_err),
        .err_clr      (err_clr),
        .seq_done_cnt (seq_done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; seq_in = '0; seq_valid = 1'b0; pop = 1'b0; err_clr = 1'b0;
        tick();
        check("rst_sym_valid", 32'(sym_valid), 0);
        check("rst_seq_ready", 32'(seq_ready), 1);
        check("rst_restrict", 32'(restrict_out), 0);
        check("rst_cnt", 32'(seq_done_cnt), 0);
        check("rst_perm_err", 32'(perm_err), 0);
        check("rst_pop_err", 32'(pop_err), 0);
        rst = 1'b0;
        tick();

        // Single word, bypass load, then four pops.
        seq_in = 8'hE4; seq_valid = 1'b1;
        tick();
        seq_valid = 1'b0;
        check("t1_valid", 32'(sym_valid), 1);
        check("t1_ready", 32'(seq_ready), 1);
        pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t1_sym", 32'(sym), 32'(k));
            tick();
        end
        pop = 1'b0;
        check("t1_empty", 32'(sym_valid), 0);
        check("t1_restrict", 32'(restrict_out), 3);
        check("t1_cnt", 32'(seq_done_cnt), 1);
        check("t1_perm_err", 32'(perm_err), 0);

        // Back-to-back words fill cur and nxt; third word waits.
        seq_valid = 1'b1; seq_in = 8'hE4;
        tick();
        check("t2_ready_a", 32'(seq_ready), 1);
        seq_in = 8'h1B;
        tick();
        check("t2_ready_b", 32'(seq_ready), 0);
        seq_in = 8'hD8;
        tick();
        check("t2_held", 32'(seq_ready), 0);
        check("t2_sym_head", 32'(sym), 0);
        pop = 1'b1;
        tick(); tick(); tick(); tick();
        check("t2_sym_1b", 32'(sym), 3);
        check("t2_ready_free", 32'(seq_ready), 1);
        check("t2_cnt", 32'(seq_done_cnt), 2);
        tick();
        seq_valid = 1'b0;
        check("t2_ready_3rd", 32'(seq_ready), 0);
        check("t2_sym_1b1", 32'(sym), 2);
        tick(); tick(); tick();
        check("t2_sym_d8", 32'(sym), 0);
        check("t2_cnt3", 32'(seq_done_cnt), 3);
        tick();
        check("t2_d8_1", 32'(sym), 2);
        tick();
        check("t2_d8_2", 32'(sym), 1);
        tick();
        check("t2_d8_3", 32'(sym), 3);
        tick();
        pop = 1'b0;
        check("t2_empty", 32'(sym_valid), 0);
        check("t2_cnt4", 32'(seq_done_cnt), 4);
        check("t2_restrict", 32'(restrict_out), 3);

        // Duplicate symbols flag perm_err but still dispense unchanged.
        seq_valid = 1'b1; seq_in = 8'h05;
        tick();
        seq_valid = 1'b0;
        check("t4_perm_err", 32'(perm_err), 1);
        pop = 1'b1;
        check("t4_sym0", 32'(sym), 1); tick();
        check("t4_sym1", 32'(sym), 1); tick();
        check("t4_sym2", 32'(sym), 0); tick();
        check("t4_sym3", 32'(sym), 0); tick();
        pop = 1'b0;
        check("t4_cnt", 32'(seq_done_cnt), 5);
        check("t4_err_held", 32'(perm_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", 32'(perm_err), 0);

        // Pop while empty; set beats a same-cycle clear.
        pop = 1'b1;
        tick();
        check("t5_pop_err", 32'(pop_err), 1);
        check("t5_no_valid", 32'(sym_valid), 0);
        check("t5_cnt", 32'(seq_done_cnt), 5);
        err_clr = 1'b1;
        tick();
        check("t5_set_wins", 32'(pop_err), 1);
        pop = 1'b0;
        tick();
        err_clr = 1'b0;
        check("t5_cleared", 32'(pop_err), 0);

        // Continuous generator with pop held high for 40 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_rst_cnt", 32'(seq_done_cnt), 0);
        seq_in = 8'hE4; seq_valid = 1'b1; pop = 1'b1;
        tick();
        for (int i = 1; i < 40; i++) begin
            check("t3_valid", 32'(sym_valid), 1);
            check("t3_sym", 32'(sym), 32'((i - 1) % 4));
            tick();
        end
        check("t3_cnt", 32'(seq_done_cnt), 9);
        check("t3_pop_err", 32'(pop_err), 1);
        tick(); tick(); tick();
        pop = 1'b0; seq_valid = 1'b0;
        check("t6_pre_ready", 32'(seq_ready), 0);
        check("t6_pre_sym", 32'(sym), 2);
        check("t6_pre_cnt", 32'(seq_done_cnt), 10);
        check("t6_pre_restrict", 32'(restrict_out), 1);

        // Asynchronous reset mid-sequence, observed before any clock edge.
        rst = 1'b1;
        #2;
        check("t6_sym_valid", 32'(sym_valid), 0);
        check("t6_ready", 32'(seq_ready), 1);
        check("t6_restrict", 32'(restrict_out), 0);
        check("t6_cnt", 32'(seq_done_cnt), 0);
        check("t6_pop_err", 32'(pop_err), 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_after", 32'(sym_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
